sha256_block_sequencer: RTL and testbench
=========================================

SHA256_BLOCK_SEQUENCER -- requirements
Module: sha256_block_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 48: maximum WAIT-state cycles before abort.
REQ-002 SHALL have parameter CNT_W, default 16: width of the block counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-low.
REQ-005 blk_valid  input  1  a 512-bit message block is offered.
REQ-006 blk_ready  output  1  sequencer accepts the block this cycle.
REQ-007 blk_data  input  512  padded block, bit 511 = first message bit.
REQ-008 blk_last  input  1  block is the final block of its message.
REQ-009 core_start  output  1  one-cycle pulse that launches the round engine.
REQ-010 core_block  output  512  registered block driven to the round engine.
REQ-011 core_hin  output  256  chaining value driven to the round engine, H0 in [255:224].
REQ-012 core_done  input  1  one-cycle pulse: round engine finished.
REQ-013 core_digest  input  256  core_hin plus final working variables, valid with core_done.
REQ-014 digest_valid  output  1  final message digest available.
REQ-015 digest_ready  input  1  consumer takes the digest.
REQ-016 digest  output  256  final message digest.
REQ-017 blk_count  output  CNT_W  blocks completed in the current message.
REQ-018 error  output  1  sticky timeout flag.

Function
REQ-019 SHALL implement the states IDLE, START, WAIT and DONE, encoded in a single state register.
REQ-020 blk_ready SHALL be 1 only in IDLE; a block is accepted when blk_valid && blk_ready.
REQ-021 On acceptance: core_block <= blk_data; last_q <= blk_last; if new_msg=1 then core_hin <= IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19) and blk_count <= 0; next state START.
REQ-022 START SHALL last exactly one cycle with core_start=1; the next state is WAIT, and the watchdog counter is cleared.
REQ-023 core_start SHALL be 0 in every state except START.
REQ-024 core_block and core_hin SHALL stay stable from START until the state leaves WAIT.
REQ-025 In WAIT on core_done: core_hin <= core_digest; blk_count <= blk_count+1 (wraps modulo 2^CNT_W); if last_q then digest <= core_digest, digest_valid <= 1, new_msg <= 1, next state DONE; otherwise new_msg <= 0, next state IDLE.
REQ-026 In WAIT without core_done the watchdog SHALL increment; when it reaches TIMEOUT_CYCLES-1 without core_done, the block SHALL set error <= 1 and new_msg <= 1, and go to IDLE (message aborted, no digest).
REQ-027 core_done arriving in the same cycle as the watchdog limit SHALL count as completion, not timeout.
REQ-028 core_done SHALL be ignored in IDLE, START and DONE.
REQ-029 In DONE, digest_valid=1 and digest SHALL hold until digest_ready=1; on that cycle the next state is IDLE and digest_valid <= 0.
REQ-030 blk_valid SHALL be ignored outside IDLE, with no data captured.
REQ-031 Latency: block accepted at edge T gives core_start high in cycle T+1; core_done in cycle T+1+L gives digest_valid high from edge T+2+L.
REQ-032 error SHALL stay 1 until reset and SHALL NOT block further operation.
REQ-033 Back-to-back sustained throughput SHALL be one block per (L+2) cycles.

Reset
REQ-034 When reset=0 at a clock edge: state=IDLE, new_msg=1, blk_ready=1 after release, core_start=0, digest_valid=0, digest=0, core_block=0, core_hin=IV, blk_count=0, error=0, watchdog=0.
REQ-035 Reset asserted in any state, including mid-WAIT, SHALL abort the message; a later core_done from the stale run SHALL be ignored because the state is IDLE.

Verification
REQ-036 Single block "abc" (61626380 00..00 00000018), blk_last=1, core model L=32 -> one core_start pulse, core_hin=IV, digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, blk_count=1.
REQ-037 Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> second core_hin equals first core_digest; digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; blk_count=2.
REQ-038 Hold digest_ready=0 for 10 cycles after digest_valid rises -> digest_valid and digest stable, blk_ready=0 and a concurrent blk_valid is not accepted; digest_ready=1 -> IDLE the next cycle.
REQ-039 Core model never asserts core_done -> error=1 exactly TIMEOUT_CYCLES-1 cycles after WAIT entry, digest_valid stays 0, next accepted block starts from IV.
REQ-040 reset=0 during WAIT of the first block of a two-block message, then core_done pulsed -> no state change; then "abc" alone -> correct "abc" digest.
REQ-041 core_done on the exact watchdog-limit cycle -> completion taken, error stays 0.

Source files
------------

// File: rtl/sha256_block_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sha256_block_sequencer
//  Purpose  : Feeds 512-bit padded message blocks to an external SHA-256
//             round engine. It tracks the chaining value across the blocks of
//             a message and presents the final digest. A watchdog aborts a
//             message whose round engine never answers.
//  Ports    : clk, reset (sync, active-low)
//             blk_valid/blk_ready/blk_data/blk_last : block input handshake
//             core_start/core_block/core_hin        : round engine launch
//             core_done/core_digest                 : round engine result
//             digest_valid/digest_ready/digest      : final digest handshake
//             blk_count : blocks completed in current message
//             error     : sticky watchdog timeout flag
//  Revision : 1.0 - initial release
// ============================================================================
module sha256_block_sequencer #(
  parameter int TIMEOUT_CYCLES = 48,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [511:0]     blk_data,
  input  logic             blk_last,
  output logic             core_start,
  output logic [511:0]     core_block,
  output logic [255:0]     core_hin,
  input  logic             core_done,
  input  logic [255:0]     core_digest,
  output logic             digest_valid,
  input  logic             digest_ready,
  output logic [255:0]     digest,
  output logic [CNT_W-1:0] blk_count,
  output logic             error
);

  localparam logic [255:0] c_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam int c_WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_new_msg;
  logic              r_last;
  logic              r_digest_valid;
  logic              r_error;
  logic [511:0]      r_core_block;
  logic [255:0]      r_core_hin;
  logic [255:0]      r_digest;
  logic [CNT_W-1:0]  r_blk_count;
  logic [c_WD_W-1:0] r_wdog;
  logic [c_WD_W-1:0] w_wdog_inc;
  logic              w_ready;
  logic              w_start;
  logic              w_accept;
  logic              w_take;
  logic              w_timeout;

  assign w_wdog_inc = r_wdog + c_WD_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_take      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (blk_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_start     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the limit cycle wins over the timeout.
        if (core_done) begin
          w_take      = 1'b1;
          w_state_nxt = r_last ? S_DONE : S_IDLE;
        end else if (w_wdog_inc == c_WD_LIMIT) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        if (digest_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_new_msg      <= 1'b1;
      r_last         <= 1'b0;
      r_digest_valid <= 1'b0;
      r_error        <= 1'b0;
      r_core_block   <= '0;
      r_core_hin     <= c_IV;
      r_digest       <= '0;
      r_blk_count    <= '0;
      r_wdog         <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_core_block <= blk_data;
        r_last       <= blk_last;
        if (r_new_msg) begin
          r_core_hin  <= c_IV;
          r_blk_count <= '0;
        end
      end
      if (w_start) begin
        r_wdog <= '0;
      end else if (r_state == S_WAIT && !core_done) begin
        r_wdog <= w_wdog_inc;
      end
      if (w_take) begin
        r_core_hin  <= core_digest;
        r_blk_count <= r_blk_count + CNT_W'(1);
        if (r_last) begin
          r_digest       <= core_digest;
          r_digest_valid <= 1'b1;
          r_new_msg      <= 1'b1;
        end else begin
          r_new_msg <= 1'b0;
        end
      end
      if (w_timeout) begin
        // Abort: next accepted block restarts from the IV.
        r_error   <= 1'b1;
        r_new_msg <= 1'b1;
      end
      if (r_state == S_DONE && digest_ready) begin
        r_digest_valid <= 1'b0;
      end
    end
  end

  assign blk_ready    = w_ready;
  assign core_start   = w_start;
  assign core_block   = r_core_block;
  assign core_hin     = r_core_hin;
  assign digest_valid = r_digest_valid;
  assign digest       = r_digest;
  assign blk_count    = r_blk_count;
  assign error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_sha256_block_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sha256_block_sequencer
//  Purpose  : Self-checking bench for sha256_block_sequencer. A behavioural
//             SHA-256 compression function stands in for the round engine;
//             expected digests are the published SHA-256 test values.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_block_sequencer;

  localparam int TIMEOUT_CYCLES = 48;
  localparam int CNT_W          = 16;

  localparam logic [255:0] c_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] c_ABC_BLK = {32'h61626380, 416'h0, 64'h18};
  localparam logic [255:0] c_ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [447:0] c_M2 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
  localparam logic [511:0] c_M2_B1 = {c_M2, 64'h8000000000000000};
  localparam logic [511:0] c_M2_B2 = {448'h0, 64'h1c0};
  localparam logic [255:0] c_M2_DIG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic             clk = 1'b0;
  logic             reset;
  logic             blk_valid;
  logic             blk_ready;
  logic [511:0]     blk_data;
  logic             blk_last;
  logic             core_start;
  logic [511:0]     core_block;
  logic [255:0]     core_hin;
  logic             core_done;
  logic [255:0]     core_digest;
  logic             digest_valid;
  logic             digest_ready;
  logic [255:0]     digest;
  logic [CNT_W-1:0] blk_count;
  logic             error;

  int n_vec = 0;
  int n_bad = 0;

  sha256_block_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .blk_data    (blk_data),
    .blk_last    (blk_last),
    .core_start  (core_start),
    .core_block  (core_block),
    .core_hin    (core_hin),
    .core_done   (core_done),
    .core_digest (core_digest),
    .digest_valid(digest_valid),
    .digest_ready(digest_ready),
    .digest      (digest),
    .blk_count   (blk_count),
    .error       (error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference round engine: returns hin plus the final working variables.
  function automatic logic [255:0] sha_engine(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = hin[255:224]; b = hin[223:192]; c = hin[191:160]; d = hin[159:128];
    e = hin[127:96];  f = hin[95:64];   g = hin[63:32];   h = hin[31:0];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e,  hin[95:64] + f,   hin[63:32] + g,   hin[31:0] + h};
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer a block in IDLE; return one cycle later with core_start checked.
  task automatic issue_block(input logic [511:0] d, input logic l, input logic [255:0] exp_hin);
    int guard = 0;
    while (!blk_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("blk_ready_before_issue", {511'd0, blk_ready}, 512'd1);
    blk_valid = 1'b1;
    blk_data  = d;
    blk_last  = l;
    @(negedge clk);
    blk_valid = 1'b0;
    blk_data  = {16{32'hdeadbeef}};
    chk("core_start", {511'd0, core_start}, 512'd1);
    chk("core_hin", {256'd0, core_hin}, {256'd0, exp_hin});
    chk("core_block", core_block, d);
  endtask

  // Engine answers lat cycles after the start cycle with a one-cycle done.
  task automatic finish_block(input int lat, input logic [511:0] d, input logic [255:0] exp_hin,
                              output logic [255:0] cd);
    cd = sha_engine(core_hin, core_block);
    repeat (lat) @(negedge clk);
    chk("busy_in_wait", {511'd0, blk_ready}, 512'd0);
    chk("hin_stable", {256'd0, core_hin}, {256'd0, exp_hin});
    chk("block_stable", core_block, d);
    core_done   = 1'b1;
    core_digest = cd;
    @(negedge clk);
    core_done   = 1'b0;
    core_digest = {8{32'h0badf00d}};
  endtask

  task automatic release_digest();
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    chk("dv_after_release", {511'd0, digest_valid}, 512'd0);
    chk("idle_after_release", {511'd0, blk_ready}, 512'd1);
  endtask

  typedef struct {
    logic [511:0]     data;
    logic             last;
    int               lat;
    logic             hin_iv;
    logic [CNT_W-1:0] exp_cnt;
    logic [255:0]     exp_dig;
  } vec_t;

  localparam int NV = 6;

  initial begin
    vec_t         tbl [NV];
    logic [255:0] prev_cd;
    logic [255:0] exp_h;
    logic [255:0] cd;

    tbl[0] = '{c_ABC_BLK, 1'b1, 32, 1'b1, 16'd1, c_ABC_DIG};
    tbl[1] = '{c_M2_B1,   1'b0, 1,  1'b1, 16'd1, 256'd0};
    tbl[2] = '{c_M2_B2,   1'b1, 5,  1'b0, 16'd2, c_M2_DIG};
    tbl[3] = '{c_ABC_BLK, 1'b1, 3,  1'b1, 16'd1, c_ABC_DIG};
    tbl[4] = '{c_M2_B1,   1'b0, 7,  1'b1, 16'd1, 256'd0};
    tbl[5] = '{c_M2_B2,   1'b1, 2,  1'b0, 16'd2, c_M2_DIG};
    prev_cd = c_IV;

    reset        = 1'b0;
    blk_valid    = 1'b0;
    blk_data     = '0;
    blk_last     = 1'b0;
    core_done    = 1'b0;
    core_digest  = '0;
    digest_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_blk_ready", {511'd0, blk_ready}, 512'd1);
    chk("rst_core_start", {511'd0, core_start}, 512'd0);
    chk("rst_digest_valid", {511'd0, digest_valid}, 512'd0);
    chk("rst_digest", {256'd0, digest}, 512'd0);
    chk("rst_core_block", core_block, 512'd0);
    chk("rst_core_hin", {256'd0, core_hin}, {256'd0, c_IV});
    chk("rst_blk_count", {{(512-CNT_W){1'b0}}, blk_count}, 512'd0);
    chk("rst_error", {511'd0, error}, 512'd0);

    // Table-driven messages
    for (int i = 0; i < NV; i++) begin
      exp_h = tbl[i].hin_iv ? c_IV : prev_cd;
      issue_block(tbl[i].data, tbl[i].last, exp_h);
      @(negedge clk);
      chk("start_one_cycle", {511'd0, core_start}, 512'd0);
      finish_block(tbl[i].lat - 1, tbl[i].data, exp_h, prev_cd);
      chk("blk_count", {{(512-CNT_W){1'b0}}, blk_count}, {{(512-CNT_W){1'b0}}, tbl[i].exp_cnt});
      if (tbl[i].last) begin
        chk("digest_valid", {511'd0, digest_valid}, 512'd1);
        chk("digest", {256'd0, digest}, {256'd0, tbl[i].exp_dig});
        release_digest();
      end else begin
        chk("no_digest_mid_msg", {511'd0, digest_valid}, 512'd0);
        chk("idle_mid_msg", {511'd0, blk_ready}, 512'd1);
      end
    end

    // Consumer stalls: digest holds, new blocks refused
    issue_block(c_ABC_BLK, 1'b1, c_IV);
    finish_block(4, c_ABC_BLK, c_IV, cd);
    blk_valid = 1'b1;
    blk_data  = c_M2_B1;
    blk_last  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("hold_dv", {511'd0, digest_valid}, 512'd1);
      chk("hold_digest", {256'd0, digest}, {256'd0, c_ABC_DIG});
      chk("hold_not_ready", {511'd0, blk_ready}, 512'd0);
      chk("hold_no_start", {511'd0, core_start}, 512'd0);
      @(negedge clk);
    end
    blk_valid = 1'b0;
    release_digest();
    chk("no_capture_in_done", core_block, c_ABC_BLK);

    // core_done on the watchdog limit cycle counts as completion
    issue_block(c_ABC_BLK, 1'b1, c_IV);
    finish_block(TIMEOUT_CYCLES - 1, c_ABC_BLK, c_IV, cd);
    chk("limit_no_error", {511'd0, error}, 512'd0);
    chk("limit_dv", {511'd0, digest_valid}, 512'd1);
    chk("limit_digest", {256'd0, digest}, {256'd0, c_ABC_DIG});
    release_digest();

    // Engine never answers: timeout TIMEOUT_CYCLES-1 cycles after WAIT entry
    issue_block(c_M2_B1, 1'b0, c_IV);
    repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
    chk("pre_timeout_error", {511'd0, error}, 512'd0);
    chk("pre_timeout_busy", {511'd0, blk_ready}, 512'd0);
    @(negedge clk);
    chk("timeout_error", {511'd0, error}, 512'd1);
    chk("timeout_idle", {511'd0, blk_ready}, 512'd1);
    chk("timeout_no_dv", {511'd0, digest_valid}, 512'd0);
    issue_block(c_ABC_BLK, 1'b1, c_IV);
    finish_block(6, c_ABC_BLK, c_IV, cd);
    chk("after_to_digest", {256'd0, digest}, {256'd0, c_ABC_DIG});
    chk("after_to_count", {{(512-CNT_W){1'b0}}, blk_count}, 512'd1);
    chk("error_sticky", {511'd0, error}, 512'd1);
    release_digest();

    // Reset mid-WAIT, then a stale core_done
    issue_block(c_M2_B1, 1'b0, c_IV);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    core_done   = 1'b1;
    core_digest = {8{32'h12345678}};
    @(negedge clk);
    core_done = 1'b0;
    chk("stale_idle", {511'd0, blk_ready}, 512'd1);
    chk("stale_no_start", {511'd0, core_start}, 512'd0);
    chk("stale_count", {{(512-CNT_W){1'b0}}, blk_count}, 512'd0);
    chk("stale_hin", {256'd0, core_hin}, {256'd0, c_IV});
    chk("stale_error_cleared", {511'd0, error}, 512'd0);
    chk("stale_no_dv", {511'd0, digest_valid}, 512'd0);
    issue_block(c_ABC_BLK, 1'b1, c_IV);
    finish_block(8, c_ABC_BLK, c_IV, cd);
    chk("post_rst_digest", {256'd0, digest}, {256'd0, c_ABC_DIG});
    chk("post_rst_count", {{(512-CNT_W){1'b0}}, blk_count}, 512'd1);
    release_digest();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
